// File: rtl/serial_rx_fifo.sv
// UART receive FIFO, first-word-fall-through; push shows on outputs 1 cycle after the strobe, bytes pushed while full are dropped with a sticky overrun.
// Optional macro SERIAL_RX_FIFO_THRESH_INT_EN: int_o on occupancy >= INT_THRESHOLD or overrun, else int_o = ~empty_o.
module serial_rx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int INT_THRESHOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxdReady_i,
    input  logic [7:0]            rxdData_i,
    input  logic                  readEnable_i,
    input  logic                  clearOverrun_i,
    output logic [7:0]            dataLoad_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overrun_o,
    output logic                  int_o
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem_q [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;

    logic empty_w;
    logic full_w;
    logic push_ok;
    logic pop_ok;
    logic drop_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A pop on a full FIFO frees the slot the coincident push needs.
    assign pop_ok  = readEnable_i & ~empty_w;
    assign push_ok = rxdReady_i & (~full_w | readEnable_i);
    assign drop_w  = rxdReady_i & full_w & ~readEnable_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
        // A new drop wins over a coincident clear.
        if (drop_w) begin
            overrun_d = 1'b1;
        end else if (clearOverrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left out of reset; stale bytes stay hidden behind count.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= rxdData_i;
        end
    end

    assign dataLoad_o = empty_w ? 8'h00 : mem_q[rd_ptr_q];
    assign empty_o    = empty_w;
    assign full_o     = full_w;
    assign count_o    = count_q;
    assign overrun_o  = overrun_q;

`ifdef SERIAL_RX_FIFO_THRESH_INT_EN
    localparam logic [DEPTH_LOG2:0] THRESH = INT_THRESHOLD[DEPTH_LOG2:0];
    assign int_o = (count_q >= THRESH) | overrun_q;
`else
    assign int_o = ~empty_w;
`endif

endmodule

// File: doc/serial_rx_fifo.md
SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set the FIFO depth to 2^DEPTH_LOG2 bytes (16 by default).
REQ-002 Parameter INT_THRESHOLD, default 8, SHALL set the occupancy level that raises the threshold interrupt.
REQ-003 clk, input, 1: the single clock (25 MHz system clock); all state SHALL update on its rising edge only.
REQ-004 rst, input, 1: reset, synchronous, active-high.
REQ-005 rxdReady_i, input, 1: one-cycle strobe from the UART receiver; a received byte is valid.
REQ-006 rxdData_i, input, 8: received byte, sampled only when rxdReady_i=1.
REQ-007 readEnable_i, input, 1: one-cycle pop strobe from the serial register interface.
REQ-008 clearOverrun_i, input, 1: clears the sticky overrun flag.
REQ-009 dataLoad_o, output, 8: oldest stored byte (head of the FIFO).
REQ-010 empty_o, output, 1: FIFO holds 0 bytes.
REQ-011 full_o, output, 1: FIFO holds 2^DEPTH_LOG2 bytes.
REQ-012 count_o, output, DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
REQ-013 overrun_o, output, 1: sticky flag; a byte was dropped.
REQ-014 int_o, output, 1: receive interrupt request to the CPU interrupt vector.

Function
REQ-015 Push: rxdReady_i=1 and full_o=0 SHALL write rxdData_i at the write pointer, advance it, and increment count_o on the next edge.
REQ-016 Pop: readEnable_i=1 and empty_o=0 SHALL advance the read pointer and decrement count_o on the next edge.
REQ-017 Pointers SHALL be DEPTH_LOG2 bits wide and wrap from 2^DEPTH_LOG2-1 to 0.
REQ-018 dataLoad_o SHALL be first-word-fall-through: it equals the head byte whenever empty_o=0, and it reads 8'h00 when empty_o=1.
REQ-019 A pushed byte SHALL appear on dataLoad_o and count_o exactly 1 cycle after the rxdReady_i strobe.
REQ-020 Pop on empty: no pointer or count change, no error flag.
REQ-021 Push on full with no pop: byte dropped, FIFO contents unchanged, overrun_o=1 from the next cycle.
REQ-022 Simultaneous push and pop, FIFO non-empty (including full): both take effect, count_o unchanged, no overrun.
REQ-023 Simultaneous push and pop, FIFO empty: push takes effect, pop ignored (no bypass), count_o becomes 1.
REQ-024 overrun_o SHALL stay 1 until clearOverrun_i=1 or rst; if clearOverrun_i and a new overrun occur in the same cycle, overrun_o SHALL be 1.
REQ-025 empty_o, full_o and int_o SHALL be derived from registered count_o only, with no combinational path from inputs.

Reset
REQ-026 rst=1 at a clock edge SHALL clear both pointers, count_o, and overrun_o, giving empty_o=1, full_o=0, dataLoad_o=8'h00, int_o=0.
REQ-027 rxdReady_i, readEnable_i and clearOverrun_i SHALL be ignored in any cycle with rst=1; a byte strobed during reset is lost.
REQ-028 Storage array contents SHALL NOT be cleared by reset and SHALL NOT be observable until rewritten.

Configuration
REQ-029 Macro SERIAL_RX_FIFO_THRESH_INT_EN defined: int_o SHALL be 1 when count_o >= INT_THRESHOLD or overrun_o=1.
REQ-030 Macro SERIAL_RX_FIFO_THRESH_INT_EN undefined: int_o SHALL equal ~empty_o, and INT_THRESHOLD SHALL be unused.

Verification
REQ-031 Push 8'h41, 8'h42, 8'h43 at separate cycles, then 3 pops -> dataLoad_o reads 41, 42, 43 in order, count_o goes 3→0, empty_o=1.
REQ-032 Push 17 bytes 8'h00..8'h10 with no pops -> full_o=1 after the 16th byte, overrun_o=1, and popping 16 times yields 00..0F (8'h10 is dropped).
REQ-033 FIFO full, then push 8'hAA with a simultaneous pop -> count_o stays 16, overrun_o stays 0, and 8'hAA is the last byte out.
REQ-034 Push 20 and pop 20 bytes, interleaved so the pointers wrap -> output order matches input order and no overrun occurs.
REQ-035 Push 5 bytes, then assert rst for 1 cycle with a coincident rxdReady_i -> count_o=0, empty_o=1, and the coincident byte is never output.
REQ-036 With SERIAL_RX_FIFO_THRESH_INT_EN defined, push 7 bytes -> int_o=0; push the 8th byte -> int_o=1 the next cycle. With the macro undefined, int_o=1 after the first byte.
